// File: rtl/drain_pkg.sv
// Shared types and sizing helpers for the result-drain slice (os_result_drain, rc_index_counter).
// The CKSUM state is only reached when DRAIN_CHECKSUM_EN is defined.
package drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CKSUM = 2'd2
    } drain_state_t;

    // Index width for a dimension of n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned elem_offset(input int unsigned r, input int unsigned c,
                                                input int unsigned cols, input int unsigned ws);
        return (r * cols + c) * ws;
    endfunction

endpackage

// File: rtl/rc_index_counter.sv
// Row-major row/col index counter with clear, increment, per-dimension wrap flags and last detect.
module rc_index_counter
    import drain_pkg::*;
#(
    parameter  int unsigned ROWS  = 4,
    parameter  int unsigned COLS  = 4,
    localparam int unsigned ROW_W = idx_width(ROWS),
    localparam int unsigned COL_W = idx_width(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             col_wrap_o,
    output logic             row_wrap_o,
    output logic             last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        col_wrap_o = (col_q == COL_W'(COLS - 1));
        row_wrap_o = (row_q == ROW_W'(ROWS - 1));
        last_o     = col_wrap_o & row_wrap_o;
        row_o      = row_q;
        col_o      = col_q;
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_wrap_o) begin
                col_d = '0;
                row_d = row_wrap_o ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/os_result_drain.sv
// Snapshots the systolic array result on a matrix_rdy rising edge and streams it row-major over valid/ready.
// Define DRAIN_CHECKSUM_EN to append a mod-2^WORD_SIZE checksum beat to every frame.
module os_result_drain
    import drain_pkg::*;
#(
    parameter  int unsigned ROWS      = 4,
    parameter  int unsigned COLS      = 4,
    parameter  int unsigned WORD_SIZE = 16,
    localparam int unsigned ROW_W     = idx_width(ROWS),
    localparam int unsigned COL_W     = idx_width(COLS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROWS*COLS*WORD_SIZE-1:0]  output_matrix,
    input  logic                            matrix_rdy,
    output logic [WORD_SIZE-1:0]            out_data,
    output logic [ROW_W-1:0]                out_row,
    output logic [COL_W-1:0]                out_col,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy,
    output logic                            overrun
);

    drain_state_t                   state_q, state_d;
    logic [ROWS*COLS*WORD_SIZE-1:0] snap_q, snap_d;
    logic                           rdy_q;
    logic                           seen_low_q;
    logic                           overrun_q, overrun_d;
    logic                           rise;
    logic                           accept;
    logic                           cnt_clr, cnt_inc;
    logic [ROW_W-1:0]               row;
    logic [COL_W-1:0]               col;
    logic                           col_wrap, row_wrap, last;
    logic [WORD_SIZE-1:0]           elem;
`ifdef DRAIN_CHECKSUM_EN
    logic [WORD_SIZE-1:0]           sum_q, sum_d;
`endif

    // seen_low_q keeps a level still high across reset from looking like a fresh edge.
    assign rise   = matrix_rdy & ~rdy_q & seen_low_q;
    assign accept = out_valid & out_ready;

    rc_index_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .row_o      (row),
        .col_o      (col),
        .col_wrap_o (col_wrap),
        .row_wrap_o (row_wrap),
        .last_o     (last)
    );

    always_comb begin
        elem = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (row == ROW_W'(r) && col == COL_W'(c)) begin
                    elem = snap_q[elem_offset(r, c, COLS, WORD_SIZE) +: WORD_SIZE];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        overrun_d = overrun_q | (rise & (state_q != IDLE));
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
`ifdef DRAIN_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    snap_d  = output_matrix;
                    cnt_clr = 1'b1;
                    state_d = DRAIN;
`ifdef DRAIN_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            DRAIN: begin
                if (accept) begin
                    cnt_inc = 1'b1;
`ifdef DRAIN_CHECKSUM_EN
                    sum_d   = sum_q + elem;
                    if (row_wrap && col_wrap) state_d = CKSUM;
`else
                    if (row_wrap && col_wrap) state_d = IDLE;
`endif
                end
            end
`ifdef DRAIN_CHECKSUM_EN
            CKSUM: begin
                if (accept) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q != IDLE);
        busy      = out_valid;
        overrun   = overrun_q;
        out_row   = (state_q == DRAIN) ? row : '0;
        out_col   = (state_q == DRAIN) ? col : '0;
        out_data  = (state_q == DRAIN) ? elem : '0;
`ifdef DRAIN_CHECKSUM_EN
        out_last  = (state_q == CKSUM);
        if (state_q == CKSUM) out_data = sum_q;
`else
        out_last  = (state_q == DRAIN) & last;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            rdy_q      <= 1'b0;
            seen_low_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef DRAIN_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            rdy_q      <= matrix_rdy;
            seen_low_q <= seen_low_q | ~matrix_rdy;
            overrun_q  <= overrun_d;
`ifdef DRAIN_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: doc/os_result_drain.md
Name: os_result_drain

Overview:
- Sits directly downstream of Top_BISR_STW_systolic.
- Snapshots the flattened output_matrix when matrix_rdy rises.
- Streams the snapshot word-serially, row-major, over a valid/ready interface, tagging each word with its row/col and a last flag.
- Decouples the array from the host or scoreboard, so the array may start the next matrix while the previous result drains.

Parameters:
- ROWS, 4, array rows
- COLS, 4, array columns
- WORD_SIZE, 16, bits per result element

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- output_matrix  in  ROWS*COLS*WORD_SIZE  flattened result; element (r,c) at bits ((r*COLS+c)*WORD_SIZE) +: WORD_SIZE
- matrix_rdy  in  1  result-valid level from array; a 0->1 transition marks a new result
- out_data  out  WORD_SIZE  current element (or checksum, see Optional Feature)
- out_row  out  $clog2(ROWS)  row index of out_data
- out_col  out  $clog2(COLS)  column index of out_data
- out_valid  out  1  out_data/out_row/out_col/out_last are valid
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready
- out_last  out  1  final beat of the frame
- busy  out  1  a snapshot is held and not yet fully drained
- overrun  out  1  sticky: a new result arrived while busy

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all outputs 0; snapshot register cleared; matrix_rdy edge register cleared to 0.
- Edge detect:
  - rdy_q registers matrix_rdy each cycle.
  - rise = matrix_rdy & ~rdy_q.
  - A level held high produces no retrigger.
- States IDLE, DRAIN.
- IDLE:
  - On rise: capture the whole output_matrix into the snapshot in the same posedge; zero the index counters; go to DRAIN.
  - busy and out_valid go 1 in the cycle after rise is sampled (latency 1 clk, rise to first valid beat).
- DRAIN:
  - out_data is the snapshot element at (out_row,out_col).
  - out_valid stays 1 until the final beat is accepted.
  - Outputs hold stable while out_valid && !out_ready.
  - On accept: col++; at col==COLS-1, col wraps to 0 and row++.
  - out_last = (row==ROWS-1 && col==COLS-1).
  - On acceptance of the last beat: go to IDLE; out_valid, busy and out_last drop next cycle.
- Throughput: one beat per cycle with out_ready held 1. A frame is exactly ROWS*COLS beats.
- Rise while in DRAIN (including the cycle the last beat is accepted):
  - The snapshot is not overwritten and the frame completes intact.
  - overrun is set to 1 and stays 1 until reset.
  - The new result is dropped, not queued.
- Rise in the same cycle the drain returns to IDLE: treated as overrun (dropped). The next rise is captured normally.
- Reset mid-drain: the frame is abandoned and outputs go to reset values next cycle. If matrix_rdy is still high after reset, no capture occurs until it falls and rises again.
- The snapshot is independent of later output_matrix changes (e.g. the BISR-corrected update). Only an edge recaptures.

Optional Feature:
- DRAIN_CHECKSUM_EN defined:
  - Keeps sum = mod-2^WORD_SIZE sum of all accepted element beats, cleared at capture.
  - After element (ROWS-1,COLS-1) is accepted, emits one extra beat: out_data = sum, out_row = 0, out_col = 0, out_last = 1.
  - out_last is 0 on the element beats.
  - Frame length is ROWS*COLS+1 beats. The sum excludes the checksum beat itself.
- Undefined: no checksum logic; the frame is ROWS*COLS beats with out_last on the final element.

Decomposition:
- Shared package drain_pkg:
  - drain_state_t enum {IDLE, DRAIN, CKSUM}; CKSUM is used only under DRAIN_CHECKSUM_EN.
  - localparam functions for ROW_W = $clog2(ROWS) and COL_W = $clog2(COLS), each with a minimum of 1.
  - element-offset helper (r*COLS+c)*WORD_SIZE.
- One sub-module, rc_index_counter: row/col counter with inc, clear and wrap outputs, and last detect. Reusable by the upstream matrix loader.

Test Plan:
- 4x4 with output_matrix rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; matrix_rdy 0->1; out_ready=1:
  - out_valid rises 1 cycle after the edge.
  - 16 consecutive beats 1..16 with (row,col) from (0,0) to (3,3); out_last only on 16.
  - busy falls after the last beat; overrun stays 0.
- Same frame, out_ready toggled 1,0,0,1,... randomly: data and indices held stable while stalled; no beat lost or duplicated; still 16 beats.
- Change output_matrix to all 0xFFFF at beat 5 without an edge: the remaining beats still carry the original values 6..16.
- Pulse matrix_rdy 0->1 again at beat 8: the frame completes with 1..16, overrun=1, and no second frame starts. overrun clears only on rst=0.
- Hold rst=0 at beat 3: out_valid, busy and overrun go 0 next cycle. With matrix_rdy held at 1 through reset release, no frame starts until matrix_rdy goes 0 then 1.
- With DRAIN_CHECKSUM_EN and the first frame: 17 beats; the final beat is out_data=136 (0x0088), out_last=1, and beat 16 has out_last=0.
